cfa_window_5x5: RTL and testbench
=================================

CFA_WINDOW_5X5 -- requirements
Module: cfa_window_5x5

Interface
REQ-001 Parameter: pixelBitWidth, 12, bits per CFA pixel.
REQ-002 Parameter: IMG_WIDTH, 64, pixels per line (legal range 8..2048).
REQ-003 Parameter: IMG_HEIGHT, 64, lines per frame (legal range 6..2048).
REQ-004 The block SHALL use exactly one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-008 Port: pix_valid  input  1  pix_in holds a valid pixel this cycle.
REQ-009 Port: pix_in  input  pixelBitWidth  raster-order CFA pixel.
REQ-010 Port: win  output  25*pixelBitWidth  packed 5x5 window; tap e<i>t<j> occupies bits [((i-1)*5+(j-1))*pixelBitWidth +: pixelBitWidth].
REQ-011 Port: win_valid  output  1  win holds a new window this cycle.
REQ-012 Port: busy  output  1  high in FILL and STREAM.
REQ-013 Port: frame_done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-014 Pixel accepted: the block SHALL accept a pixel on any cycle with pix_valid=1 and busy=1; pix_valid is ignored otherwise. There is no backpressure.
REQ-015 Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) SHALL both clear on start.
- col advances on each accept and wraps to 0 at IMG_WIDTH-1.
- row increments on that wrap.
REQ-016 Line storage: four line buffers of IMG_WIDTH entries each SHALL hold the previous four lines.
- A 5x5 shift register holds the newest five columns of rows row-4..row.
REQ-017 Tap mapping: e1 is the oldest row (row-4) and e5 the current row; t1 is the leftmost column (col-4) and t5 the current column.
REQ-018 Output timing: win_valid SHALL be 1 in the cycle after accepting pixel (r,c) with r>=4 and c>=4, and 0 in all other cycles.
- Latency is 1 cycle.
- Exactly (IMG_HEIGHT-4)*(IMG_WIDTH-4) windows are produced per frame.
REQ-019 Border handling: no padding and no window spanning a line wrap; columns 0..3 of each line produce no window.
REQ-020 Output hold: win SHALL hold its last value when win_valid=0.
REQ-021 Input gaps: gaps in pix_valid SHALL freeze all state and change no window content.
REQ-022 FSM states: IDLE, FILL, STREAM, DONE.
- IDLE->FILL on start.
- FILL->STREAM on accepting pixel (3, IMG_WIDTH-1).
- STREAM->DONE on accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- DONE->IDLE unconditionally after 1 cycle.
REQ-023 frame_done SHALL be 1 exactly in the DONE cycle, which coincides with the final win_valid.
REQ-024 start in FILL, STREAM or DONE SHALL be ignored.
REQ-025 start coincident with rst SHALL be ignored.
REQ-026 Line-buffer contents need no clearing; stale data SHALL never reach win while win_valid=1.

Reset
REQ-027 rst SHALL force state IDLE and clear row and col.
- Outputs after rst: win=0, win_valid=0, busy=0, frame_done=0.
- This applies at any point, including mid-frame; rst has priority over all other inputs.
REQ-028 After a mid-frame reset, a new start SHALL produce a frame whose output is identical to that from a never-interrupted block.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, pixelBitWidth=12, pix_in = raster index)
REQ-029 First window: start, then 48 back-to-back pixels.
- The first win_valid comes the cycle after index 36 is accepted.
- Required values: e1t1=0, e1t5=4, e3t3=18, e5t5=36.
- Exactly 8 windows are produced in total.
REQ-030 Line wrap: after indices 40..43 are accepted, win_valid=0.
- After index 44: e1t1=8, e5t1=40, e5t5=44.
REQ-031 Input gaps: pix_valid alternating 1/0 SHALL give the same 8 windows in the same order as REQ-029.
- frame_done pulses once, one cycle after index 47 is accepted.
REQ-032 Reset mid-frame: rst asserted after 20 accepts -> next cycle busy=0, win=0, win_valid=0.
- Restart plus a full frame -> first window as in REQ-029.
REQ-033 Ignored inputs:
- start pulsed while busy -> counters unaffected, window count still 8.
- pix_valid while in IDLE -> no state change.

Source files
------------

// File: rtl/cfa_window_5x5.sv
`default_nettype none
// ============================================================================
// Module      : cfa_window_5x5
// Description : Streams a raster-order CFA image and emits a 5x5 pixel
//               neighbourhood for every pixel at (row>=4, col>=4).
//               Four line buffers hold the previous four lines; a 5x5 shift
//               register holds the newest five columns of rows row-4..row.
//               The window register only loads on a valid window, so it holds
//               its value across border columns and input gaps.
// Ports       : clk        - sole clock, rising edge
//               rst        - synchronous active-high reset (highest priority)
//               start      - one-cycle frame start, honoured only in IDLE
//               pix_valid  - pix_in carries a pixel this cycle
//               pix_in     - raster-order CFA pixel
//               win        - packed window; tap e<i>t<j> at
//                            [((i-1)*5+(j-1))*pixelBitWidth +: pixelBitWidth]
//               win_valid  - win holds a new window this cycle
//               busy       - high in FILL and STREAM
//               frame_done - one-cycle pulse in the DONE state
// Revision    : 1.0 - initial release
// ============================================================================
module cfa_window_5x5 #(
    parameter int pixelBitWidth = 12,
    parameter int IMG_WIDTH     = 64,
    parameter int IMG_HEIGHT    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         pix_valid,
    input  logic [pixelBitWidth-1:0]     pix_in,
    output logic [25*pixelBitWidth-1:0]  win,
    output logic                         win_valid,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] C_COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] C_ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] C_COL_WIN   = CW'(4);
    localparam logic [RW-1:0] C_ROW_WIN   = RW'(4);
    localparam logic [RW-1:0] C_ROW_FILLN = RW'(3);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 col_q, col_d;
    logic [RW-1:0]                 row_q, row_d;
    logic [25*pixelBitWidth-1:0]   win_q, win_d;
    logic                          win_valid_q, win_valid_d;
    logic                          busy_q, busy_d;
    logic                          frame_done_q, frame_done_d;

    // sr[i][j]: i=0 is the oldest row (e1), j=4 is the newest column (t5)
    logic [pixelBitWidth-1:0]      sr_q [5][5];
    logic [pixelBitWidth-1:0]      sr_d [5][5];

    // line_buf[0] holds row-1, line_buf[3] holds row-4
    logic [pixelBitWidth-1:0]      line_buf_q [4][IMG_WIDTH];

    logic                          w_accept;
    logic                          w_col_last;
    logic                          w_row_last;
    logic [pixelBitWidth-1:0]      w_column [5];

    assign w_accept   = pix_valid && ((state_q == ST_FILL) || (state_q == ST_STREAM));
    assign w_col_last = (col_q == C_COL_LAST);
    assign w_row_last = (row_q == C_ROW_LAST);

    // New column entering the shift register, oldest row first
    always_comb begin
        w_column[0] = line_buf_q[3][col_q];
        w_column[1] = line_buf_q[2][col_q];
        w_column[2] = line_buf_q[1][col_q];
        w_column[3] = line_buf_q[0][col_q];
        w_column[4] = pix_in;
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        sr_d        = sr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_FILL, ST_STREAM: begin
                if (w_accept) begin
                    for (int i = 0; i < 5; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            sr_d[i][j] = sr_q[i][j+1];
                        end
                        sr_d[i][4] = w_column[i];
                    end

                    if (w_col_last) begin
                        col_d = '0;
                        row_d = w_row_last ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end

                    // Columns 0..3 of a line would mix in the previous line,
                    // so they never produce a window.
                    if ((row_q >= C_ROW_WIN) && (col_q >= C_COL_WIN)) begin
                        win_valid_d = 1'b1;
                        for (int i = 0; i < 5; i++) begin
                            for (int j = 0; j < 5; j++) begin
                                win_d[(i*5+j)*pixelBitWidth +: pixelBitWidth] = sr_d[i][j];
                            end
                        end
                    end

                    if ((state_q == ST_FILL) && (row_q == C_ROW_FILLN) && w_col_last) begin
                        state_d = ST_STREAM;
                    end else if ((state_q == ST_STREAM) && w_row_last && w_col_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d == ST_FILL) || (state_d == ST_STREAM);
        frame_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    sr_q[i][j] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            sr_q         <= sr_d;
        end
    end

    // Line buffers are never cleared: rows 0..3 of each frame overwrite
    // every entry before the first window can read it.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            line_buf_q[0][col_q] <= pix_in;
            line_buf_q[1][col_q] <= line_buf_q[0][col_q];
            line_buf_q[2][col_q] <= line_buf_q[1][col_q];
            line_buf_q[3][col_q] <= line_buf_q[2][col_q];
        end
    end

    assign win        = win_q;
    assign win_valid  = win_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_cfa_window_5x5.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfa_window_5x5
// Description : Self-checking bench for cfa_window_5x5 (8x6 image, 12-bit).
//               A frame-level reference model stores accepted pixels in an
//               image array and derives each expected window directly from
//               image coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfa_window_5x5;

    localparam int PBW = 12;
    localparam int W   = 8;
    localparam int H   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             pix_valid;
    logic [PBW-1:0]   pix_in;
    logic [25*PBW-1:0] win;
    logic             win_valid;
    logic             busy;
    logic             frame_done;

    cfa_window_5x5 #(
        .pixelBitWidth (PBW),
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .win        (win),
        .win_valid  (win_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: 0 idle, 1 receiving a frame, 2 done cycle
    int               mstate = 0;
    int               mr = 0;
    int               mc = 0;
    int               img [H][W];
    logic [25*PBW-1:0] exp_win = '0;
    logic             exp_wv = 1'b0;
    logic             exp_fd = 1'b0;
    logic             exp_busy = 1'b0;
    bit               last_acc;
    int               wins;
    int               fds;

    function automatic logic [PBW-1:0] tap(input logic [25*PBW-1:0] w, input int i, input int j);
        return w[((i-1)*5+(j-1))*PBW +: PBW];
    endfunction

    task automatic check(input string tag, input logic [25*PBW-1:0] obs, input logic [25*PBW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, advance the model and compare all outputs.
    task automatic step(input bit s, input bit r, input bit v, input logic [PBW-1:0] d);
        start = s; rst = r; pix_valid = v; pix_in = d;
        @(posedge clk);
        #1;
        last_acc = 0;
        exp_wv   = 0;
        if (r) begin
            mstate  = 0; mr = 0; mc = 0;
            exp_win = '0;
        end else begin
            case (mstate)
                0: if (s) begin mstate = 1; mr = 0; mc = 0; end
                1: if (v) begin
                    last_acc = 1;
                    img[mr][mc] = int'(d);
                    if (mr >= 4 && mc >= 4) begin
                        exp_wv = 1;
                        for (int i = 1; i <= 5; i++)
                            for (int j = 1; j <= 5; j++)
                                exp_win[((i-1)*5+(j-1))*PBW +: PBW] = PBW'(img[mr-5+i][mc-5+j]);
                    end
                    if (mr == H-1 && mc == W-1) mstate = 2;
                    if (mc == W-1) begin mc = 0; mr++; end
                    else mc++;
                end
                default: mstate = 0;
            endcase
        end
        exp_fd   = (mstate == 2);
        exp_busy = (mstate == 1);
        check("win_valid",  {299'd0, win_valid},  {299'd0, exp_wv});
        check("frame_done", {299'd0, frame_done}, {299'd0, exp_fd});
        check("busy",       {299'd0, busy},       {299'd0, exp_busy});
        check("win",        win,                  exp_win);
        wins += int'(win_valid);
        fds  += int'(frame_done);
    endtask

    // gap: 0 back-to-back, 1 alternating, 2 random. idxdata: pixel = raster index.
    task automatic feed_frame(input int gap, input bit idxdata, input int start_at, input int abort_at);
        int idx = 0;
        int cyc = 0;
        bit v;
        logic [PBW-1:0] d;
        wins = 0; fds = 0;
        step(1, 0, 0, '0);
        while (idx < W*H) begin
            if (idx == abort_at) begin
                step(0, 1, 0, '0);
                check("rst_busy", {299'd0, busy}, '0);
                check("rst_win", win, '0);
                check("rst_wv", {299'd0, win_valid}, '0);
                return;
            end
            cyc++;
            if (cyc > 1000) begin
                check("frame_timeout", 300'(idx), 300'(W*H));
                return;
            end
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 1) : ($urandom_range(0, 3) != 0);
            d = idxdata ? PBW'(idx) : PBW'($urandom_range(0, 4095));
            step((idx == start_at) && v, 0, v, d);
            if (last_acc) begin
                if (idxdata && idx == 36) begin
                    check("first_e1t1", 300'(tap(win, 1, 1)), 300'd0);
                    check("first_e1t5", 300'(tap(win, 1, 5)), 300'd4);
                    check("first_e3t3", 300'(tap(win, 3, 3)), 300'd18);
                    check("first_e5t5", 300'(tap(win, 5, 5)), 300'd36);
                end
                if (idxdata && idx >= 40 && idx <= 43)
                    check("wrap_wv_low", {299'd0, win_valid}, '0);
                if (idxdata && idx == 44) begin
                    check("wrap_e1t1", 300'(tap(win, 1, 1)), 300'd8);
                    check("wrap_e5t1", 300'(tap(win, 5, 1)), 300'd40);
                    check("wrap_e5t5", 300'(tap(win, 5, 5)), 300'd44);
                end
                if (idx == W*H-1)
                    check("frame_done_last", {299'd0, frame_done}, 300'd1);
                idx++;
            end
        end
        check("window_count", 300'(wins), 300'(8));
        check("frame_done_count", 300'(fds), 300'(1));
    endtask

    initial begin
        start = 0; rst = 1; pix_valid = 0; pix_in = '0;
        // Reset state
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        // Directed index frame, back-to-back; start in DONE is ignored
        feed_frame(0, 1, -1, -1);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        // Same frame with alternating gaps
        feed_frame(1, 1, -1, -1);
        step(0, 0, 0, '0);
        // Mid-frame reset after 20 accepts, then full restart
        feed_frame(0, 1, -1, 20);
        feed_frame(0, 1, -1, -1);
        step(0, 0, 0, '0);
        // start pulsed while busy must not disturb the frame
        feed_frame(2, 0, 17, -1);
        step(0, 0, 0, '0);
        // pix_valid in IDLE, and start coincident with rst, are ignored
        for (int k = 0; k < 4; k++) step(0, 0, 1, PBW'($urandom_range(0, 4095)));
        step(1, 1, 1, '0);
        step(0, 0, 1, PBW'($urandom_range(0, 4095)));
        // Random-data frames with random gaps
        for (int f = 0; f < 3; f++) begin
            feed_frame(2, 0, -1, -1);
            step(0, 0, 0, '0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
